matmul_seq_ctrl: RTL

//  Sequencer for the 8-bit signed matrix-multiply datapath. On start it walks i/j/k over
//  C[A_ROWS x B_COLS] = A[A_ROWS x A_COLS] * B[A_COLS x B_COLS] and drives a shared MAC:

---
 rtl/matmul_seq_ctrl_pkg.sv | 20 ++
 rtl/matmul_nest_cnt.sv | 47 ++++
 rtl/matmul_seq_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// rtl/matmul_seq_ctrl_pkg.sv - shared state encoding and width helper for the matmul sequencer
package matmul_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/matmul_nest_cnt.sv
// rtl/matmul_nest_cnt.sv - i/j/k nested loop counter for the matmul sequencer
module matmul_nest_cnt
  import matmul_seq_ctrl_pkg::*;
#(
  parameter int A_ROWS = 2,
  parameter int A_COLS = 2,
  parameter int B_COLS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        inc_k,
  input  logic                        inc_j,
  output logic [clog2(A_ROWS)-1:0]    i,
  output logic [clog2(B_COLS)-1:0]    j,
  output logic [clog2(A_COLS)-1:0]    k,
  output logic                        last_k,
  output logic                        last_elem
);

  localparam int IW = clog2(A_ROWS);
  localparam int JW = clog2(B_COLS);
  localparam int KW = clog2(A_COLS);

  assign last_k    = (k == KW'(A_COLS - 1));
  assign last_elem = (i == IW'(A_ROWS - 1)) && (j == JW'(B_COLS - 1));

  // Moving to the next element always restarts the k walk.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (inc_j) begin
      k <= '0;
      if (j == JW'(B_COLS - 1)) begin
        j <= '0;
        i <= (i == IW'(A_ROWS - 1)) ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end else if (inc_k) begin
      k <= k + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - sequencer driving a shared MAC over C = A * B
module matmul_seq_ctrl
  import matmul_seq_ctrl_pkg::*;
#(
  parameter int A_ROWS = 2,
  parameter int A_COLS = 2,
  parameter int B_COLS = 2,
  parameter int IDX_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [IDX_W-1:0] a_idx,
  output logic [IDX_W-1:0] b_idx,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx
);

  localparam int IW = clog2(A_ROWS);
  localparam int JW = clog2(B_COLS);
  localparam int KW = clog2(A_COLS);

  state_t state, state_nx;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic last_k, last_elem;
  logic cnt_clr, inc_k, inc_j;

  matmul_nest_cnt #(
    .A_ROWS(A_ROWS),
    .A_COLS(A_COLS),
    .B_COLS(B_COLS)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc_k     (inc_k),
    .inc_j     (inc_j),
    .i         (i),
    .j         (j),
    .k         (k),
    .last_k    (last_k),
    .last_elem (last_elem)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      aborted <= 1'b0;
    end else begin
      state   <= state_nx;
      aborted <= abort && (state != ST_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    inc_k    = 1'b0;
    inc_j    = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cnt_clr  = 1'b1;
          state_nx = ST_CLR;
        end
        ST_CLR:  state_nx = ST_MAC;
        ST_MAC:  if (op_ready) begin
          if (last_k) state_nx = ST_WB;
          else        inc_k    = 1'b1;
        end
        ST_WB:   if (last_elem) begin
          state_nx = ST_DONE;
        end else begin
          inc_j    = 1'b1;
          state_nx = ST_CLR;
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Strobes are squashed in the cycle an abort is taken; mac_en also follows op_ready.
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) && !abort;
  assign mac_clr = (state == ST_CLR) && !abort;
  assign mac_en  = (state == ST_MAC) && op_ready && !abort;
  assign wr_en   = (state == ST_WB) && !abort;

  assign a_idx  = (state == ST_MAC) ? IDX_W'(i) * IDX_W'(A_COLS) + IDX_W'(k) : '0;
  assign b_idx  = (state == ST_MAC) ? IDX_W'(k) * IDX_W'(B_COLS) + IDX_W'(j) : '0;
  assign wr_idx = wr_en ? IDX_W'(i) * IDX_W'(B_COLS) + IDX_W'(j) : '0;

endmodule
